oled_i2c_tx: RTL and testbench

OLED_I2C_TX -- requirements
Module: oled_i2c_tx

---
 rtl/oled_i2c_tx.sv | 172 +++++++++++++++++
 tb/tb_oled_i2c_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/oled_i2c_tx.sv
// Write-only I2C master that sends one SSD1306 frame: START, address, control byte, data byte, STOP.
// Optional build macro OLED_I2C_ACK_CHECK_EN adds sda_in sampling at ACK slots and a sticky nack flag.
module oled_i2c_tx #(
    parameter int unsigned CLK_DIV  = 30,
    parameter logic [6:0]  DEV_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       DCn,
    input  logic [7:0] Data,
`ifdef OLED_I2C_ACK_CHECK_EN
    input  logic       sda_in,
    output logic       nack,
`endif
    output logic       busy,
    output logic       scl,
    output logic       sda
);

    localparam int unsigned QW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_phase;
    logic [1:0]    r_byte;
    logic [2:0]    r_bit;
    logic          r_ack;
    logic [7:0]    r_data;
    logic          r_dcn;
    logic          r_busy;
    logic          r_scl;
    logic          r_sda;
`ifdef OLED_I2C_ACK_CHECK_EN
    logic          r_nack;
`endif

    logic          w_wrap;
    logic [1:0]    w_next_idx;
    logic [7:0]    w_cur_byte;
    logic [7:0]    w_next_byte;

    function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic dcn,
                                            input logic [7:0] d);
        case (idx)
            2'd0:    byte_sel = {DEV_ADDR, 1'b0};
            2'd1:    byte_sel = dcn ? 8'h40 : 8'h00;
            default: byte_sel = d;
        endcase
    endfunction

    assign w_wrap      = (r_qcnt == QW'(CLK_DIV - 1));
    assign w_next_idx  = r_byte + 2'd1;
    assign w_cur_byte  = byte_sel(r_byte, r_dcn, r_data);
    assign w_next_byte = byte_sel(w_next_idx, r_dcn, r_data);

    // scl/sda are set at the edge that opens each quarter, so every output is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_qcnt  <= '0;
            r_phase <= 2'd0;
            r_byte  <= 2'd0;
            r_bit   <= 3'd0;
            r_ack   <= 1'b0;
            r_data  <= 8'h00;
            r_dcn   <= 1'b0;
            r_busy  <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
`ifdef OLED_I2C_ACK_CHECK_EN
            r_nack  <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            r_scl <= 1'b1;
            r_sda <= 1'b1;
            if (start) begin
                r_state <= S_START;
                r_data  <= Data;
                r_dcn   <= DCn;
                r_busy  <= 1'b1;
                r_sda   <= 1'b0;
                r_qcnt  <= '0;
                r_phase <= 2'd0;
`ifdef OLED_I2C_ACK_CHECK_EN
                r_nack  <= 1'b0;
`endif
            end
        end else if (!w_wrap) begin
            r_qcnt <= r_qcnt + QW'(1);
        end else begin
            r_qcnt  <= '0;
            r_phase <= r_phase + 2'd1;
            case (r_state)
                S_START: begin
                    if (r_phase == 2'd1) begin
                        r_state <= S_BITS;
                        r_phase <= 2'd0;
                        r_byte  <= 2'd0;
                        r_bit   <= 3'd7;
                        r_ack   <= 1'b0;
                        r_scl   <= 1'b0;
                        r_sda   <= DEV_ADDR[6];
                    end
                end
                S_BITS: begin
                    case (r_phase)
                        2'd1: r_scl <= 1'b1;
`ifdef OLED_I2C_ACK_CHECK_EN
                        2'd2: begin
                            if (r_ack && sda_in)
                                r_nack <= 1'b1;
                        end
`endif
                        2'd3: begin
                            r_scl <= 1'b0;
                            if (r_ack) begin
                                if (r_byte == 2'd2) begin
                                    r_state <= S_STOP;
                                    r_sda   <= 1'b0;
                                end else begin
                                    r_byte <= w_next_idx;
                                    r_bit  <= 3'd7;
                                    r_ack  <= 1'b0;
                                    r_sda  <= w_next_byte[7];
                                end
                            end else if (r_bit == 3'd0) begin
                                // ACK slot: release the line
                                r_ack <= 1'b1;
                                r_sda <= 1'b1;
                            end else begin
                                r_bit <= r_bit - 3'd1;
                                r_sda <= w_cur_byte[r_bit - 3'd1];
                            end
                        end
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (r_phase)
                        2'd0: r_scl <= 1'b1;
                        2'd1: r_sda <= 1'b1;
                        2'd3: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_byte  <= 2'd0;
                            r_bit   <= 3'd0;
                            r_ack   <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign scl  = r_scl;
    assign sda  = r_sda;
`ifdef OLED_I2C_ACK_CHECK_EN
    assign nack = r_nack;
`endif

endmodule

// File: tb/tb_oled_i2c_tx.sv
// Directed bench for oled_i2c_tx: decodes the I2C line into bytes and checks frame shape and busy timing.
`timescale 1ns/1ps
module tb_oled_i2c_tx;

    localparam int CD   = 4;
    localparam int NCYC = 114 * CD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       DCn   = 1'b0;
    logic [7:0] Data  = 8'h00;
    logic       busy, scl, sda;
`ifdef OLED_I2C_ACK_CHECK_EN
    logic       sda_in, nack;
    int         ack_sel = -1;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;

    // line decoder state
    int   m_starts = 0;
    int   m_stops  = 0;
    int   m_nbits  = 0;
    logic m_bits [0:63];
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;

    oled_i2c_tx #(.CLK_DIV(CD), .DEV_ADDR(7'h3C)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .DCn    (DCn),
        .Data   (Data),
`ifdef OLED_I2C_ACK_CHECK_EN
        .sda_in (sda_in),
        .nack   (nack),
`endif
        .busy   (busy),
        .scl    (scl),
        .sda    (sda)
    );

    always #5 clk = ~clk;

`ifdef OLED_I2C_ACK_CHECK_EN
    // slave NACKs the selected ACK slot: bit count 9k+9 holds from its scl rise to the next one
    assign sda_in = (ack_sel >= 0) && (m_nbits == ack_sel * 9 + 9);
`endif

    always @(negedge clk) begin
        if (scl && p_scl && (sda !== p_sda)) begin
            if (!sda) begin
                m_starts++;
                m_nbits = 0;
            end else begin
                m_stops++;
            end
        end
        if (scl && !p_scl && m_nbits < 64) begin
            m_bits[m_nbits] = sda;
            m_nbits++;
        end
        p_scl = scl;
        p_sda = sda;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = m_bits[9*k+i];
        return b;
    endfunction

    // Called at the negedge before the accepting edge; start must already be high.
    task automatic run_check(input string nm, input logic [7:0] ec, input logic [7:0] ed,
                             input bit hold, input bit mid);
        int s0, p0, cnt;
        s0 = m_starts;
        p0 = m_stops;
        @(negedge clk);
        chk({nm, " busy_rise"}, 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        cnt = 0;
        while (busy && cnt < NCYC + 50) begin
            cnt++;
            if (mid && cnt == 50) begin
                Data = 8'h22;
                DCn  = 1'b1;
            end
            @(negedge clk);
        end
        chk({nm, " busy_len"}, 32'(cnt), 32'(NCYC));
        chk({nm, " starts"}, 32'(m_starts - s0), 32'd1);
        chk({nm, " stops"}, 32'(m_stops - p0), 32'd1);
        chk({nm, " nbits"}, 32'(m_nbits), 32'd28);
        chk({nm, " addr"}, 32'(get_byte(0)), 32'h78);
        chk({nm, " ctrl"}, 32'(get_byte(1)), 32'(ec));
        chk({nm, " data"}, 32'(get_byte(2)), 32'(ed));
        chk({nm, " acks"}, 32'({m_bits[8], m_bits[17], m_bits[26]}), 32'h7);
        chk({nm, " idle_lines"}, 32'({scl, sda}), 32'h3);
    endtask

    typedef struct {
        logic       dcn;
        logic [7:0] data;
        logic [7:0] ctrl;
    } vec_t;

    vec_t tv [5];

    initial begin
        tv[0] = '{1'b0, 8'hAE, 8'h00};
        tv[1] = '{1'b1, 8'h5A, 8'h40};
        tv[2] = '{1'b0, 8'hFF, 8'h00};
        tv[3] = '{1'b1, 8'h00, 8'h40};
        tv[4] = '{1'b1, 8'h81, 8'h40};

        repeat (3) @(negedge clk);
        chk("reset scl", 32'(scl), 32'd1);
        chk("reset sda", 32'(sda), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
`ifdef OLED_I2C_ACK_CHECK_EN
        chk("reset nack", 32'(nack), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle lines", 32'({scl, sda}), 32'h3);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            DCn   = tv[i].dcn;
            Data  = tv[i].data;
            start = 1'b1;
            run_check($sformatf("vec%0d", i), tv[i].ctrl, tv[i].data, 1'b0, 1'b0);
        end

        // start held through two frames; input changes mid-frame must not leak into the first
        @(negedge clk);
        DCn   = 1'b0;
        Data  = 8'h11;
        start = 1'b1;
        run_check("held1", 8'h00, 8'h11, 1'b1, 1'b1);
        chk("held gap busy", 32'(busy), 32'd0);
        run_check("held2", 8'h40, 8'h22, 1'b0, 1'b0);

        // asynchronous abort mid-frame
        @(negedge clk);
        DCn   = 1'b0;
        Data  = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (199) @(negedge clk);
        chk("pre-abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort scl", 32'(scl), 32'd1);
        chk("abort sda", 32'(sda), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        Data  = 8'hAF;
        start = 1'b1;
        run_check("after_abort", 8'h00, 8'hAF, 1'b0, 1'b0);

`ifdef OLED_I2C_ACK_CHECK_EN
        ack_sel = -1;
        @(negedge clk);
        DCn = 1'b0; Data = 8'h3C; start = 1'b1;
        run_check("ack_ok", 8'h00, 8'h3C, 1'b0, 1'b0);
        chk("ack_ok nack", 32'(nack), 32'd0);
        ack_sel = 1;
        @(negedge clk);
        DCn = 1'b1; Data = 8'hC5; start = 1'b1;
        run_check("ack_bad", 8'h40, 8'hC5, 1'b0, 1'b0);
        chk("ack_bad nack", 32'(nack), 32'd1);
        ack_sel = -1;
        @(negedge clk);
        DCn = 1'b0; Data = 8'h01; start = 1'b1;
        run_check("ack_clear", 8'h00, 8'h01, 1'b0, 1'b0);
        chk("ack_clear nack", 32'(nack), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
